// File: rtl/inst_encoder_pkg.sv
// Shared constants for the instruction encoder: mnemonic codes, MIPS opcodes and FSM states.
package inst_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // I-type mnemonics reuse the decoder's aluop values
    localparam logic [7:0] MN_ADDI  = 8'h08;
    localparam logic [7:0] MN_ADDIU = 8'h09;
    localparam logic [7:0] MN_SLTI  = 8'h2A;
    localparam logic [7:0] MN_SLTIU = 8'h2B;
    localparam logic [7:0] MN_ANDI  = 8'h59;
    localparam logic [7:0] MN_ORI   = 8'h5A;
    localparam logic [7:0] MN_XORI  = 8'h5B;
    localparam logic [7:0] MN_LUI   = 8'h5C;

    // R-type mnemonics are 0x80 | funct
    localparam logic [7:0] MN_SLL  = 8'h80;
    localparam logic [7:0] MN_SRL  = 8'h82;
    localparam logic [7:0] MN_SRA  = 8'h83;
    localparam logic [7:0] MN_ADD  = 8'hA0;
    localparam logic [7:0] MN_ADDU = 8'hA1;
    localparam logic [7:0] MN_SUB  = 8'hA2;
    localparam logic [7:0] MN_SUBU = 8'hA3;
    localparam logic [7:0] MN_AND  = 8'hA4;
    localparam logic [7:0] MN_OR   = 8'hA5;
    localparam logic [7:0] MN_XOR  = 8'hA6;
    localparam logic [7:0] MN_NOR  = 8'hA7;
    localparam logic [7:0] MN_SLT  = 8'hAA;
    localparam logic [7:0] MN_SLTU = 8'hAB;

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational packer: symbolic mnemonic plus register/immediate fields -> 32-bit MIPS word and legality.
module inst_enc_pack
    import inst_encoder_pkg::*;
(
    input  logic [7:0]  mn,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic [5:0] op_s;
    logic       itype_s;
    logic       rtype_s;
    logic       shift_s;

    // Classify the mnemonic, then assemble the word with the forced-zero fields applied
    always_comb begin
        op_s    = 6'd0;
        itype_s = 1'b0;
        rtype_s = 1'b0;
        shift_s = 1'b0;
        word    = 32'd0;
        legal   = 1'b0;
        case (mn)
            MN_ADDI:  begin itype_s = 1'b1; op_s = OP_ADDI;  end
            MN_ADDIU: begin itype_s = 1'b1; op_s = OP_ADDIU; end
            MN_SLTI:  begin itype_s = 1'b1; op_s = OP_SLTI;  end
            MN_SLTIU: begin itype_s = 1'b1; op_s = OP_SLTIU; end
            MN_ANDI:  begin itype_s = 1'b1; op_s = OP_ANDI;  end
            MN_ORI:   begin itype_s = 1'b1; op_s = OP_ORI;   end
            MN_XORI:  begin itype_s = 1'b1; op_s = OP_XORI;  end
            MN_LUI:   begin itype_s = 1'b1; op_s = OP_LUI;   end
            MN_SLL, MN_SRL, MN_SRA: begin
                rtype_s = 1'b1;
                shift_s = 1'b1;
            end
            MN_ADD, MN_ADDU, MN_SUB, MN_SUBU, MN_AND, MN_OR, MN_XOR, MN_NOR,
            MN_SLT, MN_SLTU: begin
                rtype_s = 1'b1;
            end
            default: begin
                itype_s = 1'b0;
                rtype_s = 1'b0;
            end
        endcase
        if (itype_s) begin
            legal = 1'b1;
            word  = {op_s, (mn == MN_LUI) ? 5'd0 : rs, rt, imm};
        end else if (rtype_s) begin
            legal = 1'b1;
            word  = {6'd0, shift_s ? 5'd0 : rs, rt, rd, shift_s ? shamt : 5'd0, mn[5:0]};
        end else begin
            legal = 1'b0;
            word  = 32'd0;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Streams encoded MIPS instructions into imem at sequential (wrapping) addresses.
// Optional INST_ENC_STATS_EN adds saturating legal/illegal request counters n_ok/n_bad.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] count,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_mn,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          err
`ifdef INST_ENC_STATS_EN
    ,
    output logic [15:0]   n_ok,
    output logic [15:0]   n_bad
`endif
);

    localparam logic [AW-1:0] ZERO_AW = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_AW  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] remaining_r;
    logic [AW-1:0] next_addr_r;
    logic          start_ok_s;
    logic          accept_s;
    logic [31:0]   pack_word_s;
    logic          pack_legal_s;

    inst_enc_pack u_pack (
        .mn    (in_mn),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .shamt (in_shamt),
        .imm   (in_imm),
        .word  (pack_word_s),
        .legal (pack_legal_s)
    );

    // A new request fits whenever the output slot is empty or is being emptied this cycle
    assign start_ok_s = start && (state_r == ST_IDLE);
    assign in_ready   = (state_r == ST_RUN) && (remaining_r != ZERO_AW) && (!wr_valid || wr_ready);
    assign accept_s   = in_valid && in_ready;

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (count == ZERO_AW) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (remaining_r == ONE_AW)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!wr_valid) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, sticky error and the registered write port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= ZERO_AW;
            wr_data     <= 32'd0;
            remaining_r <= ZERO_AW;
            next_addr_r <= ZERO_AW;
        end else begin
            busy <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done <= (state_r == ST_DONE);
            if (start_ok_s) begin
                remaining_r <= count;
                next_addr_r <= base_addr;
                err         <= 1'b0;
            end else if (accept_s) begin
                remaining_r <= remaining_r - ONE_AW;
                if (pack_legal_s) begin
                    next_addr_r <= next_addr_r + ONE_AW;
                end else begin
                    err <= 1'b1;
                end
            end
            // Illegal requests never reach the write port, so the address does not advance
            if (accept_s && pack_legal_s) begin
                wr_valid <= 1'b1;
                wr_addr  <= next_addr_r;
                wr_data  <= pack_word_s;
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
        end
    end

`ifdef INST_ENC_STATS_EN
    logic [15:0] n_ok_r;
    logic [15:0] n_bad_r;

    // Saturating legal/illegal request counters, cleared per load
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            n_ok_r  <= 16'd0;
            n_bad_r <= 16'd0;
        end else if (start_ok_s) begin
            n_ok_r  <= 16'd0;
            n_bad_r <= 16'd0;
        end else if (accept_s) begin
            if (pack_legal_s && (n_ok_r != 16'hFFFF)) begin
                n_ok_r <= n_ok_r + 16'd1;
            end
            if (!pack_legal_s && (n_bad_r != 16'hFFFF)) begin
                n_bad_r <= n_bad_r + 16'd1;
            end
        end
    end

    assign n_ok  = n_ok_r;
    assign n_bad = n_bad_r;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder against a behavioural encoding/scoreboard model.
module tb_inst_encoder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] count = '0;
    logic          busy, done, in_ready, wr_valid, err;
    logic          in_valid = 1'b0;
    logic [7:0]    in_mn = 8'd0;
    logic [4:0]    in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
    logic [15:0]   in_imm = 16'd0;
    logic          wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
`ifdef INST_ENC_STATS_EN
    logic [15:0]   n_ok, n_bad;
`endif

    inst_encoder #(.AW(AW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_mn(in_mn),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err)
`ifdef INST_ENC_STATS_EN
        , .n_ok(n_ok), .n_bad(n_bad)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int            checks = 0;
    int            failures = 0;
    wr_t           sb[$];
    int            rem_m = 0;
    logic [AW-1:0] addr_m = '0;
    logic          err_m = 1'b0;
    int            ok_m = 0, bad_m = 0;
    int            done_cnt = 0;
    int            ready_mode = 0;

    logic [7:0]  r_mn[32];
    logic [4:0]  r_rs[32], r_rt[32], r_rd[32], r_sh[32];
    logic [15:0] r_imm[32];
    logic [7:0]  legal_mn[19] = '{8'h08, 8'h09, 8'h2A, 8'h2B, 8'h59, 8'h5A, 8'h5B, 8'h5C,
                                  8'h80, 8'h82, 8'h83, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                                  8'hA5, 8'hA6, 8'hA7};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference encoder: {legal, word} from the mnemonic rules, plain integer arithmetic
    function automatic logic [32:0] ref_enc(input logic [7:0] mn, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [4:0] sh, input logic [15:0] imm);
        int op, f, w, r, s;
        case (mn)
            8'h08: op = 8;   8'h09: op = 9;   8'h2A: op = 10;  8'h2B: op = 11;
            8'h59: op = 12;  8'h5A: op = 13;  8'h5B: op = 14;  8'h5C: op = 15;
            default: op = -1;
        endcase
        if (op >= 0) begin
            r = (op == 15) ? 0 : int'(rs);
            w = op * 67108864 + r * 2097152 + int'(rt) * 65536 + int'(imm);
            return {1'b1, 32'(w)};
        end
        if (mn >= 8'h80 && mn < 8'hC0) begin
            f = int'(mn) - 128;
            if (f == 0 || f == 2 || f == 3 || (f >= 32 && f <= 39) || f == 42 || f == 43) begin
                r = (f < 4) ? 0 : int'(rs);
                s = (f < 4) ? int'(sh) : 0;
                w = r * 2097152 + int'(rt) * 65536 + int'(rd) * 2048 + s * 64 + f;
                return {1'b1, 32'(w)};
            end
        end
        return {1'b0, 32'd0};
    endfunction

    task automatic set_req(input int i, input logic [7:0] mn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm);
        r_mn[i] = mn; r_rs[i] = rs; r_rt[i] = rt; r_rd[i] = rd; r_sh[i] = sh; r_imm[i] = imm;
    endtask

    // Scoreboard/compare process: samples on the falling edge, away from DUT updates
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                sb.delete();
                rem_m = 0; err_m = 1'b0; ok_m = 0; bad_m = 0;
            end else begin
                chk("err", 64'(err), 64'(err_m));
`ifdef INST_ENC_STATS_EN
                chk("n_ok", 64'(n_ok), 64'(ok_m));
                chk("n_bad", 64'(n_bad), 64'(bad_m));
`endif
                if (wr_valid) begin
                    if (sb.size() == 0) begin
                        chk("wr_valid_without_pending", 64'(wr_valid), 64'(0));
                    end else begin
                        chk("wr_addr", 64'(wr_addr), 64'(sb[0].a));
                        chk("wr_data", 64'(wr_data), 64'(sb[0].d));
                        if (wr_ready) void'(sb.pop_front());
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_pending_writes", 64'(sb.size()), 64'(0));
                    chk("done_remaining", 64'(rem_m), 64'(0));
                end
                if (start) begin
                    rem_m = int'(count); addr_m = base_addr; err_m = 1'b0; ok_m = 0; bad_m = 0;
                end else if (in_valid && in_ready) begin
                    if (rem_m == 0) chk("accept_with_zero_remaining", 64'(in_ready), 64'(0));
                    else rem_m--;
                    e = ref_enc(in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm);
                    if (e[32]) begin
                        sb.push_back('{a: addr_m, d: e[31:0]});
                        addr_m = addr_m + 10'd1;
                        if (ok_m < 65535) ok_m++;
                    end else begin
                        err_m = 1'b1;
                        if (bad_m < 65535) bad_m++;
                    end
                end
            end
        end
    end

    // wr_ready pattern: 0 always ready, 1 random, 2 two stall cycles per write, 3 never ready
    initial begin
        int sc;
        sc = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: wr_ready = 1'b1;
                1: wr_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (wr_valid && sc < 2) begin wr_ready = 1'b0; sc++; end
                    else begin wr_ready = 1'b1; sc = 0; end
                end
                default: wr_ready = 1'b0;
            endcase
        end
    end

    task automatic run_load(input logic [AW-1:0] b, input int c, input int rmode, input bit gaps);
        int  idx, guard;
        bit  first;
        ready_mode = rmode;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; count = AW'(c);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; guard = 0; first = 1'b1;
        while (idx < c && guard < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_mn = r_mn[idx]; in_rs = r_rs[idx]; in_rt = r_rt[idx];
            in_rd = r_rd[idx]; in_shamt = r_sh[idx]; in_imm = r_imm[idx];
            @(negedge clk);
            if (first) begin chk("busy_in_run", 64'(busy), 64'(1)); first = 1'b0; end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (idx < c) chk("requests_consumed", 64'(idx), 64'(c));
        guard = 0;
        while (done_cnt == 0 && guard < 200) begin @(posedge clk); guard++; end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("writes_drained", 64'(sb.size()), 64'(0));
        ready_mode = 0;
    endtask

    initial begin
        int c, guard;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_wr_valid", 64'(wr_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        resetn = 1'b1;

        chk("model_ori", 64'(ref_enc(8'h5A, 5'd8, 5'd9, 5'd0, 5'd0, 16'h00FF)), {31'd0, 1'b1, 32'h350900FF});
        chk("model_addu", 64'(ref_enc(8'hA1, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0)), {31'd0, 1'b1, 32'h00221821});
        chk("model_lui", 64'(ref_enc(8'h5C, 5'd5, 5'd4, 5'd0, 5'd0, 16'h1234)), {31'd0, 1'b1, 32'h3C041234});
        chk("model_sll", 64'(ref_enc(8'h80, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0)), {31'd0, 1'b1, 32'h00011100});
        chk("model_illegal", 64'(ref_enc(8'hFF, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1)), 64'(0));

        set_req(0, 8'h5A, 5'd8, 5'd9, 5'd0, 5'd0, 16'h00FF);
        run_load(10'h010, 1, 0, 1'b0);

        set_req(0, 8'hA1, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0000);
        set_req(1, 8'h5C, 5'd5, 5'd4, 5'd0, 5'd0, 16'h1234);
        set_req(2, 8'h80, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0000);
        run_load(10'h100, 3, 0, 1'b0);

        set_req(0, 8'h08, 5'd3, 5'd4, 5'd0, 5'd0, 16'hFFFF);
        set_req(1, 8'hA5, 5'd9, 5'd10, 5'd11, 5'd0, 16'h0000);
        set_req(2, 8'h83, 5'd0, 5'd31, 5'd30, 5'd31, 16'h0000);
        run_load(10'h3FF, 3, 2, 1'b0);
        chk("wrap_next_addr", 64'(addr_m), 64'(10'h002));

        set_req(0, 8'h59, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00F0);
        set_req(1, 8'hFF, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0001);
        set_req(2, 8'hAB, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0000);
        run_load(10'h200, 3, 0, 1'b0);
        chk("err_sticky", 64'(err), 64'(1));
`ifdef INST_ENC_STATS_EN
        chk("n_bad_one", 64'(n_bad), 64'(1));
        chk("n_ok_two", 64'(n_ok), 64'(2));
`endif

        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h123; count = 10'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("cnt0_done_c1", 64'(done), 64'(0));
        chk("cnt0_busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("cnt0_done_c2", 64'(done), 64'(1));
        @(negedge clk);
        chk("cnt0_done_c3", 64'(done), 64'(0));
        chk("cnt0_no_write", 64'(wr_valid), 64'(0));
        chk("cnt0_err_cleared", 64'(err), 64'(0));

        for (int l = 0; l < 10; l++) begin
            c = $urandom_range(1, 14);
            for (int i = 0; i < c; i++) begin
                set_req(i,
                        ($urandom_range(0, 5) == 0) ? 8'($urandom) : legal_mn[$urandom_range(0, 18)],
                        5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            end
            run_load(AW'($urandom_range(0, 1023)), c, $urandom_range(0, 2), 1'b1);
        end

        done_cnt = 0;
        ready_mode = 3;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h055; count = 10'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_mn = 8'h09; in_rs = 5'd2; in_rt = 5'd3; in_imm = 16'h0042;
        guard = 0;
        while (!wr_valid && guard < 50) begin @(negedge clk); guard++; end
        chk("rst_test_wr_valid_seen", 64'(wr_valid), 64'(1));
        #1;
        resetn = 1'b0;
        #1;
        chk("abort_wr_valid", 64'(wr_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(0));
        chk("abort_idle_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
